bus_arbiter_rr: RTL and testbench

//  Round-robin arbiter for the shared 32-bit burst bus, directly upstream of the DMA controller(s) and CPU bus masters.

---
 rtl/bus_arbiter_rr_pkg.sv | 22 ++
 rtl/bus_arbiter_rr_picker.sv | 34 +++
 rtl/bus_arbiter_rr.sv | 120 ++++++++++++
 tb/tb_bus_arbiter_rr.sv | 266 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/bus_arbiter_rr_pkg.sv
// Shared definitions for the round-robin burst-bus arbiter: state encoding,
// default sizing and timeouts used by the arbiter and the bus masters.
package bus_arbiter_rr_pkg;

  localparam int unsigned DEF_NUM_MASTERS   = 4;
  localparam int unsigned DEF_BEGIN_TIMEOUT = 8;
  localparam int unsigned DEF_BUS_TIMEOUT   = 256;

  typedef enum logic [2:0] {
    ST_IDLE       = 3'd0,
    ST_GRANT      = 3'd1,
    ST_WAIT_BEGIN = 3'd2,
    ST_BUSY       = 3'd3,
    ST_TERM       = 3'd4
  } arb_state_e;

  // Larger of two timeouts; sizes the shared state counter.
  function automatic int unsigned max_u(input int unsigned a, input int unsigned b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/bus_arbiter_rr_picker.sv
// Combinational round-robin picker: first requester at or after the pointer,
// searching circularly, as a one-hot vector and as an index.
module rr_priority_picker
  import bus_arbiter_rr_pkg::*;
#(
  parameter int unsigned NUM_MASTERS = DEF_NUM_MASTERS
) (
  input  logic [NUM_MASTERS-1:0]         i_request,
  input  logic [$clog2(NUM_MASTERS)-1:0] i_ptr,
  output logic [NUM_MASTERS-1:0]         o_onehot,
  output logic [$clog2(NUM_MASTERS)-1:0] o_index,
  output logic                           o_any_valid
);

  localparam int unsigned IW = $clog2(NUM_MASTERS);

  int unsigned w_pos;

  always_comb begin
    o_onehot    = '0;
    o_index     = '0;
    o_any_valid = 1'b0;
    w_pos       = 0;
    for (int unsigned k = 0; k < NUM_MASTERS; k++) begin
      w_pos = (32'(i_ptr) + k) % NUM_MASTERS;
      if (!o_any_valid && i_request[IW'(w_pos)]) begin
        o_any_valid           = 1'b1;
        o_index               = IW'(w_pos);
        o_onehot[IW'(w_pos)]  = 1'b1;
      end
    end
  end

endmodule

// File: rtl/bus_arbiter_rr.sv
// Round-robin arbiter for the shared burst bus: one-cycle grant, ownership
// tracking from begin to end of transaction, and inactivity watchdogs.
module bus_arbiter_rr
  import bus_arbiter_rr_pkg::*;
#(
  parameter int unsigned NUM_MASTERS   = DEF_NUM_MASTERS,
  parameter int unsigned BEGIN_TIMEOUT = DEF_BEGIN_TIMEOUT,
  parameter int unsigned BUS_TIMEOUT   = DEF_BUS_TIMEOUT
) (
  input  logic                           clock,
  input  logic                           reset,
  input  logic [NUM_MASTERS-1:0]         request,
  output logic [NUM_MASTERS-1:0]         grant,
  input  logic                           begin_transaction_in,
  input  logic                           end_transaction_in,
  input  logic                           data_valid_in,
  input  logic                           busy_in,
  output logic                           end_transaction_out,
  output logic                           error_out,
  output logic [$clog2(NUM_MASTERS)-1:0] owner,
  output logic                           bus_active
);

  localparam int unsigned IW = $clog2(NUM_MASTERS);
  localparam int unsigned CW = $clog2(max_u(BEGIN_TIMEOUT, BUS_TIMEOUT)) + 1;

  arb_state_e            r_state;
  arb_state_e            w_state_nxt;
  logic [CW-1:0]         r_cnt;
  logic [CW-1:0]         w_cnt_nxt;
  logic [IW-1:0]         r_ptr;
  logic [IW-1:0]         w_ptr_nxt;
  logic [IW-1:0]         w_owner_nxt;
  logic [NUM_MASTERS-1:0] w_grant_nxt;
  logic                  w_active_nxt;
  logic                  w_term_nxt;

  logic [NUM_MASTERS-1:0] w_onehot;
  logic [IW-1:0]         w_index;
  logic                  w_any_valid;

  // A stalled slave must not keep the bus alive, so busy is deliberately ignored.
  logic w_unused_busy;
  assign w_unused_busy = busy_in;

  rr_priority_picker #(
    .NUM_MASTERS (NUM_MASTERS)
  ) u_picker (
    .i_request   (request),
    .i_ptr       (r_ptr),
    .o_onehot    (w_onehot),
    .o_index     (w_index),
    .o_any_valid (w_any_valid)
  );

  always_ff @(posedge clock) begin
    if (reset) begin
      r_state             <= ST_IDLE;
      r_cnt               <= '0;
      r_ptr               <= '0;
      grant               <= '0;
      owner               <= '0;
      bus_active          <= 1'b0;
      end_transaction_out <= 1'b0;
      error_out           <= 1'b0;
    end else begin
      r_state             <= w_state_nxt;
      r_cnt               <= w_cnt_nxt;
      r_ptr               <= w_ptr_nxt;
      grant               <= w_grant_nxt;
      owner               <= w_owner_nxt;
      bus_active          <= w_active_nxt;
      end_transaction_out <= w_term_nxt;
      error_out           <= w_term_nxt;
    end
  end

  // Next state; the counter restarts at zero on every state change.
  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = '0;
    w_ptr_nxt   = r_ptr;
    w_owner_nxt = owner;
    w_grant_nxt = '0;
    case (r_state)
      ST_IDLE: begin
        if (w_any_valid) begin
          w_state_nxt = ST_GRANT;
          w_grant_nxt = w_onehot;
          w_owner_nxt = w_index;
          w_ptr_nxt   = (w_index == IW'(NUM_MASTERS - 1)) ? '0 : w_index + IW'(1);
        end
      end
      ST_GRANT: w_state_nxt = ST_WAIT_BEGIN;
      ST_WAIT_BEGIN: begin
        if (begin_transaction_in) begin
          w_state_nxt = ST_BUSY;
        end else if (r_cnt == CW'(BEGIN_TIMEOUT - 1)) begin
          w_state_nxt = ST_IDLE;
        end else begin
          w_cnt_nxt = r_cnt + CW'(1);
        end
      end
      ST_BUSY: begin
        if (end_transaction_in) begin
          w_state_nxt = ST_IDLE;
        end else if (!data_valid_in && (r_cnt == CW'(BUS_TIMEOUT - 1))) begin
          w_state_nxt = ST_TERM;
        end else if (!data_valid_in) begin
          w_cnt_nxt = r_cnt + CW'(1);
        end
      end
      ST_TERM: w_state_nxt = ST_IDLE;
      default: w_state_nxt = ST_IDLE;
    endcase
    w_active_nxt = w_state_nxt inside {ST_GRANT, ST_WAIT_BEGIN, ST_BUSY};
    w_term_nxt   = (w_state_nxt == ST_TERM);
  end

endmodule

// File: tb/tb_bus_arbiter_rr.sv
// Scoreboard bench for bus_arbiter_rr: stimulus pushes expected grant and
// forced-termination events, a negedge monitor pops and compares them.
module tb_bus_arbiter_rr;

  logic       clock;
  logic       reset;
  logic [3:0] request;
  logic [3:0] grant;
  logic       begin_transaction_in;
  logic       end_transaction_in;
  logic       data_valid_in;
  logic       busy_in;
  logic       end_transaction_out;
  logic       error_out;
  logic [1:0] owner;
  logic       bus_active;

  bus_arbiter_rr #(
    .NUM_MASTERS   (4),
    .BEGIN_TIMEOUT (8),
    .BUS_TIMEOUT   (256)
  ) dut (
    .clock                (clock),
    .reset                (reset),
    .request              (request),
    .grant                (grant),
    .begin_transaction_in (begin_transaction_in),
    .end_transaction_in   (end_transaction_in),
    .data_valid_in        (data_valid_in),
    .busy_in              (busy_in),
    .end_transaction_out  (end_transaction_out),
    .error_out            (error_out),
    .owner                (owner),
    .bus_active           (bus_active)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  int cyc = 0;
  always @(posedge clock) cyc <= cyc + 1;

  typedef struct {
    logic [3:0] g;
    logic [1:0] o;
    int         c;
  } gexp_t;

  gexp_t gq[$];
  int    tq[$];
  gexp_t ge;
  int    te;
  int    n_checks = 0;
  int    n_err    = 0;

  task automatic push_g(input logic [3:0] g, input logic [1:0] o, input int c);
    gexp_t e;
    e.g = g;
    e.o = o;
    e.c = c;
    gq.push_back(e);
  endtask

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s cyc=%0d got=%0h want=%0h", nm, cyc, act, exp);
    end
  endtask

  task automatic wait_cyc(input int t);
    while (cyc < t) @(negedge clock);
  endtask

  // Grant at cycle g; begin after wb waiting cycles; bl cycles of BUSY with data.
  task automatic txn(input int g, input int wb, input int bl);
    wait_cyc(g + 1 + wb);
    begin_transaction_in = 1'b1;
    data_valid_in        = 1'b1;
    wait_cyc(g + 2 + wb);
    begin_transaction_in = 1'b0;
    wait_cyc(g + 1 + wb + bl);
    chk("txn_busy_active", 32'(bus_active), 32'd1);
    end_transaction_in = 1'b1;
    wait_cyc(g + 2 + wb + bl);
    end_transaction_in = 1'b0;
    data_valid_in      = 1'b0;
    chk("txn_idle_inactive", 32'(bus_active), 32'd0);
  endtask

  task automatic do_reset();
    reset = 1'b1;
    repeat (2) @(negedge clock);
    reset = 1'b0;
  endtask

  // Monitor: every grant pulse and every forced termination must be expected.
  always @(negedge clock) begin
    if (grant != 4'b0000) begin
      n_checks++;
      if (gq.size() == 0) begin
        n_err++;
        $display("FAIL unexpected_grant cyc=%0d got grant=%b owner=%0d want none", cyc, grant, owner);
      end else begin
        ge = gq.pop_front();
        if (grant !== ge.g || owner !== ge.o || cyc != ge.c) begin
          n_err++;
          $display("FAIL grant_event got grant=%b owner=%0d cyc=%0d want grant=%b owner=%0d cyc=%0d",
                   grant, owner, cyc, ge.g, ge.o, ge.c);
        end
      end
    end
    if (end_transaction_out || error_out) begin
      n_checks++;
      if (tq.size() == 0) begin
        n_err++;
        $display("FAIL unexpected_term cyc=%0d got end=%b err=%b want none", cyc, end_transaction_out, error_out);
      end else begin
        te = tq.pop_front();
        if (end_transaction_out !== 1'b1 || error_out !== 1'b1 || cyc != te) begin
          n_err++;
          $display("FAIL term_event got end=%b err=%b cyc=%0d want end=1 err=1 cyc=%0d",
                   end_transaction_out, error_out, cyc, te);
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL global_timeout cyc=%0d", cyc);
    $fatal(1, "bench time limit");
  end

  int c;

  initial begin
    reset                = 1'b1;
    request              = 4'b0000;
    begin_transaction_in = 1'b0;
    end_transaction_in   = 1'b0;
    data_valid_in        = 1'b0;
    busy_in              = 1'b0;
    repeat (3) @(negedge clock);
    chk("rst_grant", 32'(grant), 32'd0);
    chk("rst_owner", 32'(owner), 32'd0);
    chk("rst_active", 32'(bus_active), 32'd0);
    chk("rst_end", 32'(end_transaction_out), 32'd0);
    chk("rst_err", 32'(error_out), 32'd0);
    reset = 1'b0;
    @(negedge clock);

    // Single request from master 1, normal transaction.
    c = cyc;
    request = 4'b0010;
    push_g(4'b0010, 2'd1, c + 1);
    wait_cyc(c + 1);
    request = 4'b0000;
    txn(c + 1, 0, 7);

    // Two contenders from a fresh pointer: 0, 2, then wrap to 0.
    do_reset();
    c = cyc;
    request = 4'b0101;
    push_g(4'b0001, 2'd0, c + 1);
    push_g(4'b0100, 2'd2, c + 6);
    push_g(4'b0001, 2'd0, c + 11);
    txn(c + 1, 0, 2);
    txn(c + 6, 0, 2);
    wait_cyc(c + 11);
    request = 4'b0000;
    txn(c + 11, 0, 1);

    // Master 3 never begins: silent revoke; then master 0 begins on the expiry cycle.
    c = cyc;
    request = 4'b1001;
    push_g(4'b1000, 2'd3, c + 1);
    push_g(4'b0001, 2'd0, c + 11);
    wait_cyc(c + 1);
    request = 4'b0001;
    wait_cyc(c + 9);
    chk("revoke_last_active", 32'(bus_active), 32'd1);
    wait_cyc(c + 10);
    chk("revoke_inactive", 32'(bus_active), 32'd0);
    wait_cyc(c + 11);
    request = 4'b0000;
    txn(c + 11, 7, 1);

    // Bus watchdog expiry with slave busy held: forced end and error.
    c = cyc;
    request = 4'b0100;
    push_g(4'b0100, 2'd2, c + 1);
    tq.push_back(c + 259);
    wait_cyc(c + 1);
    request = 4'b0000;
    busy_in = 1'b1;
    wait_cyc(c + 2);
    begin_transaction_in = 1'b1;
    wait_cyc(c + 3);
    begin_transaction_in = 1'b0;
    wait_cyc(c + 258);
    chk("wdog_last_busy", 32'(bus_active), 32'd1);
    wait_cyc(c + 259);
    chk("wdog_term_inactive", 32'(bus_active), 32'd0);
    wait_cyc(c + 260);
    busy_in = 1'b0;
    chk("wdog_after_idle", 32'(bus_active), 32'd0);

    // Data restarts the watchdog; end on the expiry cycle wins over the error.
    c = cyc;
    request = 4'b1000;
    push_g(4'b1000, 2'd3, c + 1);
    wait_cyc(c + 1);
    request = 4'b0000;
    wait_cyc(c + 2);
    begin_transaction_in = 1'b1;
    wait_cyc(c + 3);
    begin_transaction_in = 1'b0;
    wait_cyc(c + 10);
    data_valid_in = 1'b1;
    wait_cyc(c + 11);
    data_valid_in = 1'b0;
    wait_cyc(c + 266);
    chk("endwin_busy", 32'(bus_active), 32'd1);
    end_transaction_in = 1'b1;
    wait_cyc(c + 267);
    end_transaction_in = 1'b0;
    chk("endwin_idle", 32'(bus_active), 32'd0);

    // Reset in BUSY with all masters requesting.
    c = cyc;
    request = 4'b0010;
    push_g(4'b0010, 2'd1, c + 1);
    wait_cyc(c + 1);
    request = 4'b1111;
    wait_cyc(c + 2);
    begin_transaction_in = 1'b1;
    data_valid_in        = 1'b1;
    wait_cyc(c + 3);
    begin_transaction_in = 1'b0;
    wait_cyc(c + 5);
    reset         = 1'b1;
    data_valid_in = 1'b0;
    wait_cyc(c + 6);
    chk("midrst_grant", 32'(grant), 32'd0);
    chk("midrst_active", 32'(bus_active), 32'd0);
    chk("midrst_owner", 32'(owner), 32'd0);
    chk("midrst_end", 32'(end_transaction_out), 32'd0);
    chk("midrst_err", 32'(error_out), 32'd0);
    wait_cyc(c + 7);
    reset = 1'b0;
    push_g(4'b0001, 2'd0, c + 8);
    wait_cyc(c + 8);
    request = 4'b0000;
    txn(c + 8, 0, 1);

    repeat (5) @(negedge clock);
    chk("grant_queue_drained", 32'(gq.size()), 32'd0);
    chk("term_queue_drained", 32'(tq.size()), 32'd0);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_err);
    $finish;
  end

endmodule
